// File: rtl/mul_pkg.sv
// Shared constants and types for the pipelined multiplier.
// Optional build macro MUL_SIGNED_EN selects two's-complement operands.
package mul_pkg;
  localparam int MUL_WIDTH   = 8;
  localparam int MUL_PROD_W  = 2 * MUL_WIDTH;
  localparam int MUL_LATENCY = 3;

  typedef logic [MUL_WIDTH-1:0]  operand_t;
  typedef logic [MUL_PROD_W-1:0] product_t;
endpackage

// File: rtl/mul_pp_sum.sv
// Combinational sum of WIDTH/2 shifted partial products starting at bit START of b_r.
// With MUL_SIGNED_EN defined, a_r is sign-extended and the product term for the
// multiplier's top bit is subtracted (two's-complement weight of the sign bit).
module mul_pp_sum #(
  parameter int WIDTH = 8,
  parameter int START = 0
) (
  input  logic [WIDTH-1:0]   a_r,
  input  logic [WIDTH-1:0]   b_r,
  output logic [2*WIDTH-1:0] sum
);
  localparam int N = WIDTH / 2;

  logic [2*WIDTH-1:0]          a_ext;
  logic [N-1:0][2*WIDTH-1:0]   pp;

`ifdef MUL_SIGNED_EN
  assign a_ext = {{WIDTH{a_r[WIDTH-1]}}, a_r};
`else
  assign a_ext = {{WIDTH{1'b0}}, a_r};
`endif

  // One gated, shifted copy of the multiplicand per multiplier bit.
  for (genvar i = 0; i < N; i++) begin : g_pp
    assign pp[i] = b_r[START+i] ? (a_ext << (START + i)) : '0;
  end

  // Adder chain across this half's partial products.
  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) begin
`ifdef MUL_SIGNED_EN
      if (START + i == WIDTH - 1) sum = sum - pp[i];
      else                        sum = sum + pp[i];
`else
      sum = sum + pp[i];
`endif
    end
  end
endmodule

// File: rtl/pipelined_mul8.sv
// Three-stage shift-and-add multiplier: operand register, split partial-product
// sums, final add. One product per clock, fixed 3-edge latency, registered out.
// Optional build macro MUL_SIGNED_EN selects two's-complement arithmetic.
module pipelined_mul8
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] out
);
  logic [WIDTH-1:0]   a_r, b_r;
  logic [2*WIDTH-1:0] sum_lo, sum_hi;
  logic [2*WIDTH-1:0] s_lo, s_hi;

  mul_pp_sum #(.WIDTH(WIDTH), .START(0)) u_lo (
    .a_r (a_r),
    .b_r (b_r),
    .sum (sum_lo)
  );

  mul_pp_sum #(.WIDTH(WIDTH), .START(WIDTH/2)) u_hi (
    .a_r (a_r),
    .b_r (b_r),
    .sum (sum_hi)
  );

  // Stage 1: capture operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
    end else begin
      a_r <= a;
      b_r <= b;
    end
  end

  // Stage 2: register the low and high partial-product sums.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_lo <= '0;
      s_hi <= '0;
    end else begin
      s_lo <= sum_lo;
      s_hi <= sum_hi;
    end
  end

  // Stage 3: final add into the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out <= '0;
    else     out <= s_lo + s_hi;
  end
endmodule

// File: tb/tb_pipelined_mul8.sv
// Scoreboard bench for pipelined_mul8: the driver pushes expected products,
// a negedge monitor pops them when a bench-side issue pipeline says one is due.
module tb_pipelined_mul8;
  import mul_pkg::*;

  logic     clk = 1'b0;
  logic     rst;
  operand_t a, b;
  product_t out;

  int checks   = 0;
  int failures = 0;

  product_t q[$];
  logic     issued;
  logic [MUL_LATENCY-1:0] pipe;

  pipelined_mul8 #(.WIDTH(MUL_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .out (out)
  );

  always #5 clk = ~clk;

  // Bench-side record of which edges sampled a scored operand pair.
  always @(posedge clk or posedge rst) begin
    if (rst) pipe <= '0;
    else     pipe <= {pipe[MUL_LATENCY-2:0], issued};
  end

  function automatic product_t model(input operand_t x, input operand_t y);
    product_t p;
`ifdef MUL_SIGNED_EN
    p = product_t'($signed({{MUL_WIDTH{x[MUL_WIDTH-1]}}, x}) *
                   $signed({{MUL_WIDTH{y[MUL_WIDTH-1]}}, y}));
`else
    p = product_t'({8'd0, x}) * product_t'({8'd0, y});
`endif
    return p;
  endfunction

  // Monitor: every negedge, out must equal the due product, or 0 when none is due.
  always @(negedge clk) begin
    product_t e;
    checks++;
    if (pipe[MUL_LATENCY-1] && !rst) begin
      if (q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_underflow out=%0d expected=<queued product>", out);
      end else begin
        e = q.pop_front();
        if (out !== e) begin
          failures++;
          $display("FAIL product out=%0d expected=%0d t=%0t", out, e, $time);
        end
      end
    end else if (out !== '0) begin
      failures++;
      $display("FAIL idle_zero out=%0d expected=0 rst=%0b t=%0t", out, rst, $time);
    end
  end

  task automatic drive(input operand_t x, input operand_t y, input product_t e);
    a = x; b = y; issued = 1'b1;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    a = '0; b = '0; issued = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_now(input string name, input product_t e);
    checks++;
    if (out !== e) begin
      failures++;
      $display("FAIL %s out=%0d expected=%0d", name, out, e);
    end
  endtask

  initial begin
    operand_t x, y;
    rst = 1'b1; issued = 1'b0;
    a = 8'hA5; b = 8'h3C;
    #1 check_now("reset_initial", '0);
    repeat (3) begin
      @(posedge clk); #1;
      a = a + 8'h13; b = b ^ 8'h5A;
      check_now("reset_hold", '0);
    end
    a = '0; b = '0;
    rst = 1'b0;

`ifdef MUL_SIGNED_EN
    drive(8'h80, 8'h80, 16'd16384);
    drive(8'hFF, 8'h7F, 16'hFF81);
    drive(8'hF9, 8'h06, 16'hFFD6);
    drive(8'h00, 8'hFF, 16'h0000);
    drive(8'h01, 8'h01, 16'h0001);
    drive(8'h7F, 8'h7F, 16'd16129);
`else
    // Streaming sequence, one pair per cycle.
    drive(8'd10,  8'd5,   16'd50);
    drive(8'd100, 8'd7,   16'd700);
    drive(8'd200, 8'd200, 16'd40000);
    drive(8'd99,  8'd10,  16'd990);
    drive(8'd88,  8'd99,  16'd8712);
    // Corners.
    drive(8'd255, 8'd255, 16'd65025);
    drive(8'd0,   8'd255, 16'd0);
    drive(8'd255, 8'd0,   16'd0);
    drive(8'd1,   8'd1,   16'd1);
    drive(8'd128, 8'd2,   16'd256);
`endif
    repeat (3) idle();

    // Asynchronous reset between edges clears a nonzero output at once.
    drive(8'd255, 8'd255, model(8'd255, 8'd255));
    drive(8'd255, 8'd255, model(8'd255, 8'd255));
    drive(8'd255, 8'd255, model(8'd255, 8'd255));
    check_now("preasync_nonzero", model(8'd255, 8'd255));
    a = '0; b = '0; issued = 1'b0;
    #1;
    rst = 1'b1;
    q.delete();
    #1 check_now("async_reset_drop", '0);
    @(posedge clk); #1;
    check_now("async_reset_hold", '0);
    rst = 1'b0;

    // Mid-stream half-cycle reset pulse flushes in-flight products.
    drive(8'd10,  8'd5, 16'd50);
    drive(8'd100, 8'd7, 16'd700);
    a = '0; b = '0; issued = 1'b0;
    rst = 1'b1;
    q.delete();
    #5 rst = 1'b0;
    @(posedge clk); #1;
    drive(8'd1,   8'd1, model(8'd1, 8'd1));
    drive(8'd128, 8'd2, model(8'd128, 8'd2));
    drive(8'd3,   8'd7, model(8'd3, 8'd7));

    // Random back-to-back pairs against the arithmetic model.
    for (int i = 0; i < 1000; i++) begin
      x = operand_t'($urandom_range(255, 0));
      y = operand_t'($urandom_range(255, 0));
      drive(x, y, model(x, y));
    end
    repeat (4) idle();

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d expected=0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipelined_mul8.md
Name: pipelined_mul8

Overview:
- Fully pipelined unsigned shift-and-add multiplier, 8x8 -> 16 bits.
- Accepts a new operand pair every clock; the registered product appears a fixed 3 cycles later.
- Datapath leaf block that arithmetic units instantiate where one product per cycle is needed.
- No handshake: every clock edge samples the inputs.

Parameters:
- WIDTH, 8, operand width in bits; the result is 2*WIDTH bits wide. Only 8 is required to be verified; the RTL must stay generic.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all pipeline registers.
- a  input  WIDTH  multiplicand, sampled every rising edge.
- b  input  WIDTH  multiplier, sampled every rising edge.
- out  output  2*WIDTH  registered product.

Behaviour:
- Reset:
  - While rst=1, out=0 and all internal registers are 0, independent of clk.
  - Release is seen at the next rising edge.
  - Asserting rst mid-stream flushes every in-flight product.
  - After release, out stays 0 until the first post-reset operands reach the output 3 edges later.
- Stage 1 (edge k): a_r <= a, b_r <= b.
- Stage 2 (edge k+1):
  - Partial products pp_i = b_r[i] ? (a_r << i) : 0, for i = 0..WIDTH-1.
  - Low sum s_lo <= pp_0 + ... + pp_{WIDTH/2-1}.
  - High sum s_hi <= pp_{WIDTH/2} + ... + pp_{WIDTH-1}.
  - Both sums are 2*WIDTH wide, so nothing truncates.
- Stage 3 (edge k+2): out <= s_lo + s_hi.
- Latency and throughput:
  - Operands applied before edge k give their product on out just after edge k+2.
  - Throughput is one product per cycle; back-to-back operands never interact.
- Arithmetic:
  - Exact unsigned product, no overflow possible.
  - Maximum value is 255*255 = 65025 (0xFE01).
  - Any operand of 0 yields 0.
- Internal adder chains are combinational within a stage. No multi-cycle paths.
- out is driven only by a register and has no combinational path from a or b.

Optional Feature:
- Macro MUL_SIGNED_EN.
- When defined:
  - a, b and out are two's complement.
  - Partial products are sign-extended to 2*WIDTH.
  - The partial product for b_r[WIDTH-1] is subtracted instead of added.
  - Latency and throughput are unchanged.
  - Examples: -128*-128 = 16384; -1*127 = 0xFF81.
- When not defined: unsigned behaviour exactly as specified above.

Decomposition:
- Package mul_pkg:
  - Constants MUL_WIDTH=8, MUL_PROD_W=2*MUL_WIDTH, MUL_LATENCY=3.
  - Typedefs operand_t and product_t.
- One sub-module, mul_pp_sum:
  - Combinational.
  - Takes a_r, b_r and a start index.
  - Returns the sum of WIDTH/2 shifted partial products.
  - Instantiated twice in stage 2 (low half, high half).

Test Plan:
- Reset check:
  - Assert rst with garbage on a/b and toggle clk -> out=0 throughout.
  - Assert rst asynchronously between edges -> out drops to 0 immediately.
- Streaming sequence, one pair per cycle: (10,5), (100,7), (200,200), (99,10), (88,99).
  - out shows 50, 700, 40000, 990, 8712 on consecutive cycles.
  - The first value (50) appears 3 edges after (10,5) is applied.
- Corners:
  - (255,255) -> 65025.
  - (0,255) -> 0, and (255,0) -> 0.
  - (1,1) -> 1.
  - (128,2) -> 256.
- Reset mid-stream:
  - Apply (10,5), (100,7), then pulse rst for half a cycle.
  - No 50 or 700 ever appears; out stays 0 until new post-reset operands arrive 3 edges later.
- Random back-to-back: 1000 random pairs, one per cycle -> out equals the product a*b delayed by 3 cycles, with no mismatches.
- With MUL_SIGNED_EN defined:
  - (-128,-128) -> 16384.
  - (-1,127) -> 0xFF81.
  - (-7,6) -> 0xFFD6.
